// File: rtl/ex_mem_skid_register.sv
// EX/MEM pipeline boundary: two-entry skid buffer holding the ALU result, store data,
// branch target and control bundle, with beq/bne resolved at capture time.
module ex_mem_skid_register #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     alu_out,
    input  logic                      alu_zero,
    input  logic [DATA_WIDTH-1:0]     store_data,
    input  logic [DATA_WIDTH-1:0]     branch_target,
    input  logic [REG_ADDR_WIDTH-1:0] write_reg,
    input  logic [5:0]                ctrl_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_result,
    output logic [DATA_WIDTH-1:0]     out_store_data,
    output logic [DATA_WIDTH-1:0]     out_branch_target,
    output logic [REG_ADDR_WIDTH-1:0] out_write_reg,
    output logic [3:0]                out_ctrl,
    output logic                      branch_taken
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     result;
        logic [DATA_WIDTH-1:0]     store_data;
        logic [DATA_WIDTH-1:0]     branch_target;
        logic [REG_ADDR_WIDTH-1:0] write_reg;
        logic [3:0]                ctrl;
        logic                      taken;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;
    entry_t r_main;
    entry_t r_skid;
    entry_t w_in_entry;
    logic   w_accept;
    logic   w_send;
    logic   w_load_main_in;
    logic   w_load_main_skid;
    logic   w_load_skid;

    // Capture bundle; branch decision is fixed here so MEM never sees the raw zero flag.
    always_comb begin
        w_in_entry.result        = alu_out;
        w_in_entry.store_data    = store_data;
        w_in_entry.branch_target = branch_target;
        w_in_entry.write_reg     = write_reg;
        w_in_entry.ctrl          = ctrl_in[5:2];
        w_in_entry.taken         = ctrl_in[1] & (alu_zero ^ ctrl_in[0]);
    end

    assign in_ready  = (r_state != S_TWO);
    assign out_valid = (r_state != S_EMPTY);
    assign w_accept  = in_valid & in_ready;
    assign w_send    = out_valid & out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_next_state = S_EMPTY;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_load_main_in = 1'b1;
                        w_next_state   = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_send) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid  = 1'b1;
                        w_next_state = S_TWO;
                    end else if (w_send) begin
                        w_next_state = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_send) begin
                        w_load_main_skid = 1'b1;
                        w_next_state     = S_ONE;
                    end
                end
                default: w_next_state = S_EMPTY;
            endcase
        end
    end

    // Entry storage; cleared on flush so squashed data never lingers on the outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (flush) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main <= w_in_entry;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_entry;
            end
        end
    end

    assign out_result        = r_main.result;
    assign out_store_data    = r_main.store_data;
    assign out_branch_target = r_main.branch_target;
    assign out_write_reg     = r_main.write_reg;
    assign out_ctrl          = r_main.ctrl;
    assign branch_taken      = out_valid & r_main.taken;

endmodule

// File: tb/tb_ex_mem_skid_register.sv
// Bench for ex_mem_skid_register: queue-based FIFO model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ex_mem_skid_register;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic [31:0] store_data;
    logic [31:0] branch_target;
    logic [4:0]  write_reg;
    logic [5:0]  ctrl_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic [31:0] out_branch_target;
    logic [4:0]  out_write_reg;
    logic [3:0]  out_ctrl;
    logic        branch_taken;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [31:0] sd;
        logic [31:0] bt;
        logic [4:0]  wr;
        logic [3:0]  ctrl;
        logic        taken;
    } ent_t;

    ent_t model_q[$];

    ex_mem_skid_register dut (
        .clock             (clock),
        .reset             (reset),
        .flush             (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .alu_out           (alu_out),
        .alu_zero          (alu_zero),
        .store_data        (store_data),
        .branch_target     (branch_target),
        .write_reg         (write_reg),
        .ctrl_in           (ctrl_in),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_result        (out_result),
        .out_store_data    (out_store_data),
        .out_branch_target (out_branch_target),
        .out_write_reg     (out_write_reg),
        .out_ctrl          (out_ctrl),
        .branch_taken      (branch_taken)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO of depth two; flush empties it, reset empties it immediately.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            model_q.delete();
        end else begin
            ent_t e;
            logic acc;
            logic snd;
            acc = in_valid && (model_q.size() < 2);
            snd = out_ready && (model_q.size() > 0);
            e.res   = alu_out;
            e.sd    = store_data;
            e.bt    = branch_target;
            e.wr    = write_reg;
            e.ctrl  = ctrl_in[5:2];
            e.taken = ctrl_in[1] && (ctrl_in[0] ? !alu_zero : alu_zero);
            if (flush) begin
                model_q.delete();
            end else begin
                if (snd) void'(model_q.pop_front());
                if (acc) model_q.push_back(e);
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (reset) begin
            check("m_out_valid", 32'(out_valid), 32'(model_q.size() != 0));
            check("m_in_ready", 32'(in_ready), 32'(model_q.size() < 2));
            if (model_q.size() != 0) begin
                check("m_result", out_result, model_q[0].res);
                check("m_store", out_store_data, model_q[0].sd);
                check("m_target", out_branch_target, model_q[0].bt);
                check("m_wreg", 32'(out_write_reg), 32'(model_q[0].wr));
                check("m_ctrl", 32'(out_ctrl), 32'(model_q[0].ctrl));
                check("m_taken", 32'(branch_taken), 32'(model_q[0].taken));
            end else begin
                check("m_taken_idle", 32'(branch_taken), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [5:0] c,
                         input logic z, input logic [31:0] bt);
        in_valid      = v;
        alu_out       = a;
        ctrl_in       = c;
        alu_zero      = z;
        branch_target = bt;
        store_data    = a ^ 32'hFFFF_0000;
        write_reg     = a[4:0];
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 32'h5, 6'b100000, 1'b0, 32'h0);
        repeat (3) step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_result", out_result, 32'd0);
        check("rst_ctrl", 32'(out_ctrl), 32'd0);
        check("rst_taken", 32'(branch_taken), 32'd0);

        // Single bundle, one-cycle latency
        reset = 1'b1;
        step();
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_result", out_result, 32'h5);
        check("lat_wreg", 32'(out_write_reg), 32'd5);
        drive(1'b0, 32'h0, 6'b0, 1'b0, 32'h0);
        out_ready = 1'b1;
        step();
        check("drain_valid", 32'(out_valid), 32'd0);

        // Streaming with MEM always ready
        drive(1'b1, 32'h10, 6'b110000, 1'b0, 32'h0);
        step();
        check("str0", out_result, 32'h10);
        check("str0_rdy", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h20, 6'b101000, 1'b0, 32'h0);
        step();
        check("str1", out_result, 32'h20);
        check("str1_rdy", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h30, 6'b000100, 1'b0, 32'h0);
        step();
        check("str2", out_result, 32'h30);
        check("str2_rdy", 32'(in_ready), 32'd1);
        check("str2_ctrl", 32'(out_ctrl), 32'h1);
        drive(1'b0, 32'h0, 6'b0, 1'b0, 32'h0);
        step();

        // Stall: fill both entries, third push held off
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 6'b100000, 1'b0, 32'h0);
        step();
        check("stl_rdy1", 32'(in_ready), 32'd1);
        drive(1'b1, 32'hB, 6'b100000, 1'b0, 32'h0);
        step();
        check("stl_rdy2", 32'(in_ready), 32'd0);
        check("stl_hold0", out_result, 32'hA);
        drive(1'b1, 32'hC, 6'b100000, 1'b0, 32'h0);
        step();
        check("stl_hold1", out_result, 32'hA);
        check("stl_rdy3", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        check("stl_out_b", out_result, 32'hB);
        check("stl_rdy4", 32'(in_ready), 32'd1);
        step();
        check("stl_out_c", out_result, 32'hC);
        drive(1'b0, 32'h0, 6'b0, 1'b0, 32'h0);
        step();
        check("stl_empty", 32'(out_valid), 32'd0);

        // Branch resolution
        drive(1'b1, 32'h0, 6'b000010, 1'b1, 32'h0040_0020);
        step();
        check("beq_taken", 32'(branch_taken), 32'd1);
        check("beq_target", out_branch_target, 32'h0040_0020);
        drive(1'b1, 32'h0, 6'b000011, 1'b1, 32'h0040_0040);
        step();
        check("bne_taken", 32'(branch_taken), 32'd0);
        drive(1'b1, 32'h7, 6'b000011, 1'b0, 32'h0040_0060);
        step();
        check("bne_nz_taken", 32'(branch_taken), 32'd1);
        drive(1'b0, 32'h0, 6'b0, 1'b0, 32'h0);
        step();

        // Flush while full, with a concurrent input that must be dropped
        out_ready = 1'b0;
        drive(1'b1, 32'h1, 6'b100010, 1'b1, 32'h100);
        step();
        drive(1'b1, 32'h2, 6'b100000, 1'b0, 32'h0);
        step();
        check("fl_full", 32'(in_ready), 32'd0);
        flush = 1'b1;
        drive(1'b1, 32'h99, 6'b100000, 1'b0, 32'h0);
        step();
        flush = 1'b0;
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_rdy", 32'(in_ready), 32'd1);
        check("fl_taken", 32'(branch_taken), 32'd0);
        check("fl_result", out_result, 32'd0);
        drive(1'b0, 32'h0, 6'b0, 1'b0, 32'h0);
        step();
        check("fl_never", 32'(out_valid), 32'd0);

        // Asynchronous reset between edges while full
        drive(1'b1, 32'h3, 6'b100010, 1'b1, 32'h200);
        step();
        drive(1'b1, 32'h4, 6'b100000, 1'b0, 32'h0);
        step();
        drive(1'b0, 32'h0, 6'b0, 1'b0, 32'h0);
        check("ar_full", 32'(in_ready), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_rdy", 32'(in_ready), 32'd1);
        check("ar_result", out_result, 32'd0);
        check("ar_target", out_branch_target, 32'd0);
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (2) step();
        check("ar_after", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
